// File: rtl/smart_home_pkg.sv
// Types and constants shared by the smart-home control blocks
// (weather_alarm upstream, window_actuator_ctrl downstream).
package smart_home_pkg;

  localparam int N_WIN_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    DRIVING = 2'd2,
    FAULT   = 2'd3
  } win_state_e;

endpackage

// File: rtl/limit_debounce.sv
// One limit-switch input: two-flop synchroniser followed by a counter that
// accepts a new level only after DEBOUNCE consecutive equal synced samples.
module limit_debounce #(
  parameter int DEBOUNCE = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_in,
  output logic closed
);

  localparam int CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  logic             r_sync1;
  logic             r_sync2;
  logic             r_db;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_db    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= raw_in;
      r_sync2 <= r_sync1;
      // Any sample matching the accepted level restarts the run.
      if (r_sync2 == r_db) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_W'(DEBOUNCE - 1)) begin
        r_db  <= r_sync2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign closed = r_db;

endmodule

// File: rtl/window_actuator_ctrl.sv
// Per-window close-motor controller: debounced limit feedback, per-window FSM
// with drive timeout, and a round-robin arbiter capping concurrent motors.
module window_actuator_ctrl
  import smart_home_pkg::*;
#(
  parameter int N_WIN       = N_WIN_DEFAULT,
  parameter int MAX_ACTIVE  = 2,
  parameter int TIMEOUT_CYC = 50000,
  parameter int DEBOUNCE    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_WIN-1:0] window_close_cmd,
  input  logic [N_WIN-1:0] limit_closed,
  input  logic [N_WIN-1:0] fault_clr,
  output logic [N_WIN-1:0] motor_en,
  output logic [N_WIN-1:0] window_state,
  output logic [N_WIN-1:0] fault,
  output logic             busy
);

  localparam int RR_W  = (N_WIN > 1) ? $clog2(N_WIN) : 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYC);
  localparam int CNT_W = $clog2(N_WIN + 1);

  win_state_e       r_state [N_WIN];
  logic [TMR_W-1:0] r_timer [N_WIN];
  logic [RR_W-1:0]  r_rr;
  logic [N_WIN-1:0] r_motor_en;
  logic [N_WIN-1:0] r_fault;
  logic             r_busy;

  logic [N_WIN-1:0] w_closed;
  logic [N_WIN-1:0] w_eligible;
  logic [N_WIN-1:0] w_driving;
  logic [CNT_W-1:0] w_active_cnt;
  logic             w_grant_vld;
  logic [RR_W-1:0]  w_grant_idx;
  logic [RR_W-1:0]  w_rr_next;
  logic [RR_W:0]    w_sum;
  logic             w_busy_next;

  genvar gi;
  generate
    for (gi = 0; gi < N_WIN; gi++) begin : g_win
      limit_debounce #(.DEBOUNCE(DEBOUNCE)) u_db (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw_in (limit_closed[gi]),
        .closed (w_closed[gi])
      );
      // A window leaving PENDING this cycle is not offered a grant.
      assign w_eligible[gi] = (r_state[gi] == PENDING) && window_close_cmd[gi] && !w_closed[gi];
      assign w_driving[gi]  = (r_state[gi] == DRIVING);
    end
  endgenerate

  assign window_state = ~w_closed;

  // Count uses current state, so a slot released this cycle is free next cycle.
  always_comb begin
    w_active_cnt = '0;
    for (int i = 0; i < N_WIN; i++) begin
      if (w_driving[i]) w_active_cnt = w_active_cnt + 1'b1;
    end
  end

  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    w_sum       = '0;
    if (w_active_cnt < CNT_W'(MAX_ACTIVE)) begin
      // Walk downward so the closest eligible index after r_rr wins.
      for (int k = N_WIN - 1; k >= 0; k--) begin
        w_sum = {1'b0, r_rr} + (RR_W + 1)'(k);
        if (w_sum >= (RR_W + 1)'(N_WIN)) w_sum = w_sum - (RR_W + 1)'(N_WIN);
        if (w_eligible[w_sum[RR_W-1:0]]) begin
          w_grant_vld = 1'b1;
          w_grant_idx = w_sum[RR_W-1:0];
        end
      end
    end
  end

  assign w_rr_next = (w_grant_idx == RR_W'(N_WIN - 1)) ? '0 : w_grant_idx + 1'b1;

  always_comb begin
    w_busy_next = 1'b0;
    for (int i = 0; i < N_WIN; i++) begin
      case (r_state[i])
        IDLE:    if (window_close_cmd[i] && !w_closed[i]) w_busy_next = 1'b1;
        PENDING: if (window_close_cmd[i] && !w_closed[i]) w_busy_next = 1'b1;
        DRIVING: if (!w_closed[i] && (r_timer[i] != TMR_W'(TIMEOUT_CYC - 1))) w_busy_next = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_WIN; i++) begin
        r_state[i] <= IDLE;
        r_timer[i] <= '0;
      end
      r_rr       <= '0;
      r_motor_en <= '0;
      r_fault    <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_busy <= w_busy_next;
      if (w_grant_vld) r_rr <= w_rr_next;
      for (int i = 0; i < N_WIN; i++) begin
        case (r_state[i])
          IDLE: begin
            if (window_close_cmd[i] && !w_closed[i]) r_state[i] <= PENDING;
          end
          PENDING: begin
            if (!window_close_cmd[i] || w_closed[i]) begin
              r_state[i] <= IDLE;
            end else if (w_grant_vld && (w_grant_idx == RR_W'(i))) begin
              r_state[i]    <= DRIVING;
              r_timer[i]    <= '0;
              r_motor_en[i] <= 1'b1;
            end
          end
          DRIVING: begin
            // Closing wins over a simultaneous timeout.
            if (w_closed[i]) begin
              r_state[i]    <= IDLE;
              r_motor_en[i] <= 1'b0;
            end else if (r_timer[i] == TMR_W'(TIMEOUT_CYC - 1)) begin
              r_state[i]    <= FAULT;
              r_motor_en[i] <= 1'b0;
              r_fault[i]    <= 1'b1;
            end else if (r_timer[i] != '1) begin
              r_timer[i] <= r_timer[i] + 1'b1;
            end
          end
          FAULT: begin
            if (fault_clr[i]) begin
              r_state[i] <= IDLE;
              r_fault[i] <= 1'b0;
            end
          end
          default: r_state[i] <= IDLE;
        endcase
      end
    end
  end

  assign motor_en = r_motor_en;
  assign fault    = r_fault;
  assign busy     = r_busy;

endmodule
